// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/return sequencer. It accepts ECALL, MRET or a timer
// interrupt at commit, then issues the CSR writebacks and the fetch redirect
// over a short fixed sequence while the front end is stalled.
module csr_trap_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic [63:0] trap_pc,
    input  logic        ecall_valid,
    input  logic        mret_valid,
    input  logic        timer_irq,
    input  logic [63:0] mepc,
    input  logic [63:0] mtvec,
    input  logic [63:0] mstatus,
    input  logic [63:0] mie,
    output logic        stall,
    output logic        ack,
    output logic [7:0]  wbcsren,
    output logic [63:0] wbmepc,
    output logic [63:0] wbmcause,
    output logic [63:0] wbmstatus,
    output logic [63:0] wbmip,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAVE   = 3'd1,
        STATUS = 3'd2,
        RET    = 3'd3,
        REDIR  = 3'd4
    } state_t;

    localparam logic [63:0] CAUSE_ECALL = 64'd11;
    localparam logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] MIP_MTIP    = 64'h80;

    state_t      state_q, state_d;
    logic [63:0] epc_q, epc_d;
    logic [63:0] cause_q, cause_d;
    logic        is_irq_q, is_irq_d;
    logic        from_ret_q, from_ret_d;

    logic        irq_pend;
    logic        accept;
    logic        unused_ok;

    assign irq_pend  = mstatus[3] & mie[7] & timer_irq;
    assign accept    = inst_valid & (ecall_valid | mret_valid | irq_pend);
    assign unused_ok = ^{mtvec[1:0], mie[63:8], mie[6:0]};

    // State and latched trap context; synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            epc_q      <= '0;
            cause_q    <= '0;
            is_irq_q   <= 1'b0;
            from_ret_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            is_irq_q   <= is_irq_d;
            from_ret_q <= from_ret_d;
        end
    end

    // Next-state: fixed-priority event selection in IDLE, fixed walk otherwise.
    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        is_irq_d   = is_irq_q;
        from_ret_d = from_ret_q;
        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    if (ecall_valid) begin
                        epc_d      = trap_pc;
                        cause_d    = CAUSE_ECALL;
                        is_irq_d   = 1'b0;
                        from_ret_d = 1'b0;
                        state_d    = SAVE;
                    end else if (mret_valid) begin
                        epc_d      = trap_pc;
                        is_irq_d   = 1'b0;
                        from_ret_d = 1'b1;
                        state_d    = RET;
                    end else if (irq_pend) begin
                        epc_d      = trap_pc;
                        cause_d    = CAUSE_MTI;
                        is_irq_d   = 1'b1;
                        from_ret_d = 1'b0;
                        state_d    = SAVE;
                    end
                end
            end
            SAVE:    state_d = STATUS;
            STATUS:  state_d = REDIR;
            RET:     state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: Moore writebacks per state plus the Mealy accept pulse; all quiet in reset.
    always_comb begin
        stall          = 1'b0;
        ack            = 1'b0;
        wbcsren        = '0;
        wbmepc         = '0;
        wbmcause       = '0;
        wbmstatus      = '0;
        wbmip          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ack   = 1'b1;
                        stall = 1'b1;
                    end
                end
                SAVE: begin
                    stall       = 1'b1;
                    wbcsren[0]  = 1'b1;
                    wbcsren[1]  = 1'b1;
                    wbmepc      = epc_q;
                    wbmcause    = cause_q;
                end
                STATUS: begin
                    stall            = 1'b1;
                    wbcsren[3]       = 1'b1;
                    wbmstatus        = mstatus;
                    wbmstatus[7]     = mstatus[3];
                    wbmstatus[3]     = 1'b0;
                    wbmstatus[12:11] = 2'b11;
                    if (is_irq_q) begin
                        wbcsren[5] = 1'b1;
                        wbmip      = MIP_MTIP;
                    end
                end
                RET: begin
                    stall            = 1'b1;
                    wbcsren[3]       = 1'b1;
                    wbmstatus        = mstatus;
                    wbmstatus[3]     = mstatus[7];
                    wbmstatus[7]     = 1'b1;
                    wbmstatus[12:11] = 2'b11;
                end
                REDIR: begin
                    stall          = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = from_ret_q ? mepc : {mtvec[63:2], 2'b00};
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: each cycle pushes the expected outputs to
// a scoreboard queue, which is popped and compared at the falling edge.
`timescale 1ns/1ps
module tb_csr_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [63:0] trap_pc;
    logic        ecall_valid;
    logic        mret_valid;
    logic        timer_irq;
    logic [63:0] mepc, mtvec, mstatus, mie;
    logic        stall, ack;
    logic [7:0]  wbcsren;
    logic [63:0] wbmepc, wbmcause, wbmstatus, wbmip;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct packed {
        logic        stall;
        logic        ack;
        logic [7:0]  en;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mstatus;
        logic [63:0] mip;
        logic        rv;
        logic [63:0] rpc;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    always #5 clock = ~clock;

    csr_trap_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .inst_valid     (inst_valid),
        .trap_pc        (trap_pc),
        .ecall_valid    (ecall_valid),
        .mret_valid     (mret_valid),
        .timer_irq      (timer_irq),
        .mepc           (mepc),
        .mtvec          (mtvec),
        .mstatus        (mstatus),
        .mie            (mie),
        .stall          (stall),
        .ack            (ack),
        .wbcsren        (wbcsren),
        .wbmepc         (wbmepc),
        .wbmcause       (wbmcause),
        .wbmstatus      (wbmstatus),
        .wbmip          (wbmip),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    // Push expected outputs for the current cycle, then pop and compare at negedge.
    task automatic cyc(input string tag, input logic e_stall, input logic e_ack, input logic [7:0] e_en,
                       input logic [63:0] e_mepc, input logic [63:0] e_mcause, input logic [63:0] e_mstatus,
                       input logic [63:0] e_mip, input logic e_rv, input logic [63:0] e_rpc);
        exp_t  e;
        string t;
        e = '{e_stall, e_ack, e_en, e_mepc, e_mcause, e_mstatus, e_mip, e_rv, e_rpc};
        sb.push_back(e);
        sb_tag.push_back(tag);
        @(negedge clock);
        e = sb.pop_front();
        t = sb_tag.pop_front();
        chk(t, "stall",          {63'd0, stall},          {63'd0, e.stall});
        chk(t, "ack",            {63'd0, ack},            {63'd0, e.ack});
        chk(t, "wbcsren",        {56'd0, wbcsren},        {56'd0, e.en});
        chk(t, "wbmepc",         wbmepc,                  e.mepc);
        chk(t, "wbmcause",       wbmcause,                e.mcause);
        chk(t, "wbmstatus",      wbmstatus,               e.mstatus);
        chk(t, "wbmip",          wbmip,                   e.mip);
        chk(t, "redirect_valid", {63'd0, redirect_valid}, {63'd0, e.rv});
        chk(t, "redirect_pc",    redirect_pc,             e.rpc);
        @(posedge clock);
        #1;
    endtask

    task automatic quiet(input string tag);
        cyc(tag, 1'b0, 1'b0, 8'h00, '0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic drop_inputs();
        inst_valid  = 1'b0;
        ecall_valid = 1'b0;
        mret_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inst_valid = 1'b0; trap_pc = '0; ecall_valid = 1'b0; mret_valid = 1'b0;
        timer_irq = 1'b0; mepc = '0; mtvec = 64'h8000_0800; mstatus = 64'hA_0000_1808; mie = '0;
        @(posedge clock); #1;

        // Reset: outputs silent even with an event presented
        quiet("rst0");
        inst_valid = 1'b1; ecall_valid = 1'b1; trap_pc = 64'h8000_0100;
        quiet("rst_ecall");
        reset = 1'b0;

        // ECALL accepted in first IDLE cycle after reset
        cyc("ecall_acc", 1'b1, 1'b1, 8'h00, '0, '0, '0, '0, 1'b0, '0);
        drop_inputs();
        cyc("ecall_save", 1'b1, 1'b0, 8'h03, 64'h8000_0100, 64'd11, '0, '0, 1'b0, '0);
        cyc("ecall_status", 1'b1, 1'b0, 8'h08, '0, '0, 64'hA_0000_1880, '0, 1'b0, '0);
        cyc("ecall_redir", 1'b1, 1'b0, 8'h00, '0, '0, '0, '0, 1'b1, 64'h8000_0800);
        quiet("ecall_idle");

        // MRET
        mepc = 64'h8000_0104; mstatus = 64'hA_0000_1880; trap_pc = 64'h8000_0104;
        inst_valid = 1'b1; mret_valid = 1'b1;
        cyc("mret_acc", 1'b1, 1'b1, 8'h00, '0, '0, '0, '0, 1'b0, '0);
        drop_inputs();
        cyc("mret_ret", 1'b1, 1'b0, 8'h08, '0, '0, 64'hA_0000_1888, '0, 1'b0, '0);
        cyc("mret_redir", 1'b1, 1'b0, 8'h00, '0, '0, '0, '0, 1'b1, 64'h8000_0104);
        quiet("mret_idle");

        // Timer interrupt
        mstatus = 64'hA_0000_1808; mie = 64'h80; timer_irq = 1'b1; trap_pc = 64'h8000_0200;
        inst_valid = 1'b1;
        cyc("irq_acc", 1'b1, 1'b1, 8'h00, '0, '0, '0, '0, 1'b0, '0);
        inst_valid = 1'b0;
        cyc("irq_save", 1'b1, 1'b0, 8'h03, 64'h8000_0200, 64'h8000_0000_0000_0007, '0, '0, 1'b0, '0);
        cyc("irq_status", 1'b1, 1'b0, 8'h28, '0, '0, 64'hA_0000_1880, 64'h80, 1'b0, '0);
        cyc("irq_redir", 1'b1, 1'b0, 8'h00, '0, '0, '0, '0, 1'b1, 64'h8000_0800);
        quiet("irq_idle");

        // Interrupt masked by mstatus.MIE, and an event without inst_valid
        mstatus = 64'hA_0000_1800; inst_valid = 1'b1;
        quiet("irq_masked0");
        quiet("irq_masked1");
        inst_valid = 1'b0; ecall_valid = 1'b1; mstatus = 64'hA_0000_1808;
        quiet("no_inst_valid");
        ecall_valid = 1'b0;

        // Priority: ECALL wins over MRET and pending interrupt
        trap_pc = 64'h8000_0300; inst_valid = 1'b1; ecall_valid = 1'b1; mret_valid = 1'b1;
        cyc("prio_acc", 1'b1, 1'b1, 8'h00, '0, '0, '0, '0, 1'b0, '0);
        drop_inputs();
        cyc("prio_save", 1'b1, 1'b0, 8'h03, 64'h8000_0300, 64'd11, '0, '0, 1'b0, '0);
        cyc("prio_status", 1'b1, 1'b0, 8'h08, '0, '0, 64'hA_0000_1880, '0, 1'b0, '0);
        cyc("prio_redir", 1'b1, 1'b0, 8'h00, '0, '0, '0, '0, 1'b1, 64'h8000_0800);
        timer_irq = 1'b0;
        quiet("prio_idle");

        // Busy: events during the sequence are ignored
        trap_pc = 64'h8000_0100; inst_valid = 1'b1; ecall_valid = 1'b1;
        cyc("busy_acc", 1'b1, 1'b1, 8'h00, '0, '0, '0, '0, 1'b0, '0);
        trap_pc = 64'h8000_0400;
        cyc("busy_save", 1'b1, 1'b0, 8'h03, 64'h8000_0100, 64'd11, '0, '0, 1'b0, '0);
        cyc("busy_status", 1'b1, 1'b0, 8'h08, '0, '0, 64'hA_0000_1880, '0, 1'b0, '0);
        cyc("busy_redir", 1'b1, 1'b0, 8'h00, '0, '0, '0, '0, 1'b1, 64'h8000_0800);
        drop_inputs();
        quiet("busy_idle");

        // Reset during STATUS aborts the sequence
        trap_pc = 64'h8000_0500; inst_valid = 1'b1; ecall_valid = 1'b1;
        cyc("abort_acc", 1'b1, 1'b1, 8'h00, '0, '0, '0, '0, 1'b0, '0);
        drop_inputs();
        cyc("abort_save", 1'b1, 1'b0, 8'h03, 64'h8000_0500, 64'd11, '0, '0, 1'b0, '0);
        reset = 1'b1;
        quiet("abort_status_rst");
        reset = 1'b0;
        quiet("abort_after");
        trap_pc = 64'h8000_0600; inst_valid = 1'b1; ecall_valid = 1'b1;
        cyc("abort_reacc", 1'b1, 1'b1, 8'h00, '0, '0, '0, '0, 1'b0, '0);
        drop_inputs();
        cyc("abort_resave", 1'b1, 1'b0, 8'h03, 64'h8000_0600, 64'd11, '0, '0, 1'b0, '0);
        cyc("abort_restatus", 1'b1, 1'b0, 8'h08, '0, '0, 64'hA_0000_1880, '0, 1'b0, '0);
        cyc("abort_reredir", 1'b1, 1'b0, 8'h00, '0, '0, '0, '0, 1'b1, 64'h8000_0800);
        quiet("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 The block SHALL have these ports: clock  in  1  system clock.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 inst_valid  in  1  a committing instruction is present at trap_pc this cycle.
REQ-004 trap_pc  in  64  PC of the committing instruction.
REQ-005 ecall_valid  in  1  the committing instruction is ECALL; qualified by inst_valid.
REQ-006 mret_valid  in  1  the committing instruction is MRET; qualified by inst_valid.
REQ-007 timer_irq  in  1  level machine-timer interrupt line.
REQ-008 mepc, mtvec, mstatus, mie  in  64 each  current CSR values read from the register file.
REQ-009 stall  out  1  hold the pipeline front end; the instruction at trap_pc SHALL NOT be retired while asserted.
REQ-010 ack  out  1  one-cycle pulse when an event is accepted.
REQ-011 wbcsren  out  8  CSR write enables: bit0 mepc, bit1 mcause, bit3 mstatus, bit5 mip; bits 2, 4, 6 and 7 SHALL always be 0.
REQ-012 wbmepc, wbmcause, wbmstatus, wbmip  out  64 each  CSR write data.
REQ-013 redirect_valid  out  1  one-cycle pulse; when asserted, redirect_pc is the next fetch PC.
REQ-014 redirect_pc  out  64  redirect target.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SAVE, STATUS, RET and REDIR.
REQ-016 irq_pend SHALL equal mstatus[3] & mie[7] & timer_irq.
REQ-017 In IDLE with inst_valid=1, the block SHALL select one event by fixed priority: ecall_valid, then mret_valid, then irq_pend.
REQ-018 An event with no inst_valid SHALL be ignored.
REQ-019 On acceptance, ack=1 and stall=1 in the same cycle.
REQ-020 On acceptance the block SHALL latch epc=trap_pc and the cause: ECALL 64'd11, interrupt 64'h8000_0000_0000_0007.
REQ-021 Acceptance SHALL latch is_irq for an interrupt, and the next state SHALL be SAVE; MRET SHALL go to RET.
REQ-022 In SAVE: wbcsren=8'b0000_0011, wbmepc=epc, wbmcause=cause; next state STATUS.
REQ-023 In STATUS: wbcsren[3]=1, and wbmstatus SHALL equal mstatus with bit7 (MPIE) set to mstatus[3], bit3 (MIE) cleared and bits[12:11] (MPP) set to 2'b11.
REQ-024 In STATUS when is_irq=1: wbcsren[5]=1 and wbmip=64'h80; next state REDIR.
REQ-025 STATUS SHALL sample mstatus after the SAVE write has landed (one-cycle register-file write latency).
REQ-026 In RET: wbcsren[3]=1, and wbmstatus SHALL equal mstatus with bit3 set to mstatus[7], bit7 set to 1 and MPP set to 2'b11; next state REDIR.
REQ-027 In REDIR: redirect_valid=1; next state IDLE.
REQ-028 In REDIR, redirect_pc SHALL be {mtvec[63:2],2'b00} after SAVE, and mepc after RET.
REQ-029 stall SHALL be 1 in every non-IDLE state and in the accepting IDLE cycle, and 0 otherwise.
REQ-030 Event inputs SHALL be ignored while the FSM is not in IDLE.
REQ-031 A pending level interrupt SHALL be re-evaluated only in IDLE, so it SHALL NOT re-trigger while mstatus[3]=0.
REQ-032 In cycles where an output is not defined above: wbcsren=0, redirect_valid=0 and ack=0; wb* data and redirect_pc SHALL be 0.
REQ-033 Latency, accept to redirect_valid: 3 cycles for traps (IDLE, SAVE, STATUS, REDIR) and 2 cycles for MRET (IDLE, RET, REDIR).
REQ-034 A trap sequence SHALL occupy 4 stall cycles and an MRET sequence 3 stall cycles.

Reset
REQ-035 While reset=1 the state SHALL become IDLE and epc, cause and is_irq SHALL clear to 0.
REQ-036 While reset=1 all outputs SHALL be 0, including wbcsren; no CSR write SHALL issue in that cycle.
REQ-037 Reset asserted mid-sequence SHALL abort it with no further writes or redirect.
REQ-038 The first event SHALL be accepted in the first IDLE cycle after reset deasserts.

Verification
REQ-039 ECALL: inst_valid=1, ecall_valid=1, trap_pc=0x80000100, mtvec=0x80000800, mstatus=0xA00001808 -> ack; SAVE writes mepc=0x80000100, mcause=11.
REQ-040 ECALL continued -> STATUS writes mstatus=0xA00001880; REDIR issues redirect_pc=0x80000800 exactly 3 cycles after ack.
REQ-041 MRET: mepc=0x80000104, mstatus=0xA00001880 -> RET writes mstatus=0xA00001888; redirect_pc=0x80000104 2 cycles after ack; wbcsren[1:0] never asserted.
REQ-042 Interrupt: timer_irq=1, mie=0x80, mstatus[3]=1, trap_pc=0x80000200 -> mcause=0x8000000000000007, mepc=0x80000200, wbmip=0x80.
REQ-043 Interrupt masked: the same stimulus with mstatus[3]=0 -> no ack and stall stays 0.
REQ-044 Priority: ecall_valid=1 and mret_valid=1 with irq_pend=1 -> ECALL sequence only, cause=11.
REQ-045 Busy: a second ecall_valid during SAVE is ignored, with exactly one ack.
REQ-046 Reset during STATUS -> wbcsren=0 in that cycle, no redirect_valid, and the FSM is in IDLE on the next cycle.
